// File: rtl/flop_bank_ctrl.sv
// Sequencer for a bank of active-low preset/clear D flops. It runs SET/CLR/LOAD/HOLD
// commands, keeps a shadow of the expected q, and reports and counts mismatches.
module flop_bank_ctrl #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q_in,
    output logic             rsp_valid,
    output logic             rsp_match,
    output logic [WIDTH-1:0] rsp_q,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, DRIVE, LOAD, SETTLE, CHECK} state_t;

    localparam logic [1:0]       OP_HOLD    = 2'b00;
    localparam logic [1:0]       OP_SET     = 2'b01;
    localparam logic [1:0]       OP_CLR     = 2'b10;
    localparam logic [1:0]       OP_LOAD    = 2'b11;
    localparam logic [3:0]       PULSE_INIT = 4'(PULSE_CYC - 1);
    localparam logic [WIDTH-1:0] ONES       = '1;

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [1:0]       op, op_nx;
    logic [WIDTH-1:0] data, data_nx;
    logic [WIDTH-1:0] shadow, shadow_nx;
    logic [WIDTH-1:0] preset_nx, clear_nx, d_nx;
    logic             ready_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        op_nx     = op;
        data_nx   = data;
        shadow_nx = shadow;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_nx   = cmd_op;
                    data_nx = cmd_data;
                    if (cmd_op == OP_SET || cmd_op == OP_CLR) begin
                        state_nx = DRIVE;
                        cnt_nx   = PULSE_INIT;
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            DRIVE: begin
                if (cnt == 4'd0) begin
                    state_nx  = SETTLE;
                    shadow_nx = (op == OP_SET) ? (shadow | data) : (shadow & ~data);
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            LOAD: begin
                state_nx = SETTLE;
                if (op == OP_LOAD) shadow_nx = data;
            end
            SETTLE:  state_nx = CHECK;
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        // Only one of preset/clear is ever pulled low, which keeps the illegal pair away.
        preset_nx = ONES;
        clear_nx  = ONES;
        d_nx      = shadow_nx;
        ready_nx  = (state_nx == IDLE);
        case (state_nx)
            DRIVE: begin
                if (op_nx == OP_SET) preset_nx = ~data_nx;
                else                 clear_nx  = ~data_nx;
            end
            LOAD: begin
                if (op_nx == OP_LOAD) d_nx = data_nx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op        <= OP_HOLD;
            data      <= '0;
            shadow    <= '0;
            preset    <= ONES;
            clear     <= ONES;
            d         <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_match <= 1'b0;
            rsp_q     <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            op        <= op_nx;
            data      <= data_nx;
            shadow    <= shadow_nx;
            preset    <= preset_nx;
            clear     <= clear_nx;
            d         <= d_nx;
            cmd_ready <= ready_nx;
            rsp_valid <= (state == CHECK);
            // q_in sampled here already reflects the SETTLE capture edge.
            if (state == CHECK) begin
                rsp_q     <= q_in;
                rsp_match <= (q_in == shadow);
                if (q_in != shadow) err_count <= sat_inc(err_count);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_flop_bank_ctrl.sv
// Scoreboard bench for flop_bank_ctrl driving a behavioural preset/clear flop bank
// with an optional stuck-at-1 fault mask on the returned q.
module tb_flop_bank_ctrl;
    localparam int WIDTH     = 8;
    localparam int PULSE_CYC = 2;
    localparam int CNT_W     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] preset, clear, d, q_in;
    logic             rsp_valid, rsp_match;
    logic [WIDTH-1:0] rsp_q;
    logic [CNT_W-1:0] err_count;
    logic             busy;

    always #5 clk = ~clk;

    flop_bank_ctrl #(.WIDTH(WIDTH), .PULSE_CYC(PULSE_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .preset(preset), .clear(clear),
        .d(d), .q_in(q_in), .rsp_valid(rsp_valid), .rsp_match(rsp_match),
        .rsp_q(rsp_q), .err_count(err_count), .busy(busy)
    );

    // Flop bank: preset low forces 1, else clear low forces 0, else capture d.
    logic [WIDTH-1:0] bank_q = '0;
    logic [WIDTH-1:0] stuck  = '0;
    always @(posedge clk) bank_q <= (~preset) | (clear & d);
    assign q_in = bank_q | stuck;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] q;
        logic       m;
        logic [7:0] err;
        int         lat;
        int         acc;
    } exp_t;
    exp_t sb[$];

    int         tests = 0;
    int         fails = 0;
    int         p_low = 0;
    int         c_low = 0;
    logic [7:0] p_seen = 8'hFF;
    logic [7:0] c_seen = 8'hFF;
    logic       chk_d_en = 1'b0;
    logic [7:0] chk_d_val = 8'h00;
    int         last_acc = 0;

    localparam logic [1:0] HOLD = 2'b00, SET = 2'b01, CLR = 2'b10, LOAD = 2'b11;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [1:0] op, input logic [7:0] data, input logic keep,
                        input logic push, input logic [7:0] eq, input logic em,
                        input logic [7:0] ee);
        int n;
        exp_t e;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        last_acc = cyc;
        if (push) begin
            e.q   = eq;
            e.m   = em;
            e.err = ee;
            e.lat = (op == SET || op == CLR) ? PULSE_CYC + 2 : 3;
            e.acc = cyc;
            sb.push_back(e);
        end
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            chk("preset_or_clear", preset | clear, 8'hFF);
            if (preset != 8'hFF) begin p_low++; p_seen = preset; end
            if (clear  != 8'hFF) begin c_low++; c_seen = clear;  end
            if (chk_d_en) chk("d_eq_shadow", d, chk_d_val);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_q", rsp_q, e.q);
                    chk("rsp_match", rsp_match, e.m);
                    chk("err_count", err_count, e.err);
                    chk("latency", cyc - e.acc, e.lat);
                end
            end
        end
    endtask

    initial begin
        int p0, c0, prev;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = HOLD;
        cmd_data  = '0;
        fork
            monitor();
            begin
                repeat (3) @(negedge clk);
                chk("rst_preset", preset, 8'hFF);
                chk("rst_clear", clear, 8'hFF);
                chk("rst_d", d, 8'h00);
                chk("rst_ready", cmd_ready, 1'b0);
                chk("rst_rsp_valid", rsp_valid, 1'b0);
                chk("rst_rsp_q", rsp_q, 8'h00);
                chk("rst_err", err_count, 8'h00);
                chk("rst_busy", busy, 1'b0);
                rst = 1'b0;
                @(negedge clk);
                chk("ready_after_rst", cmd_ready, 1'b1);

                // LOAD 0xA5
                send(LOAD, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 8'd0);
                chk("load_d", d, 8'hA5);
                chk("load_busy", busy, 1'b1);
                drain();

                // SET mask 0x0F from 0xA5
                p0 = p_low; c0 = c_low;
                send(SET, 8'h0F, 1'b0, 1'b1, 8'hAF, 1'b1, 8'd0);
                chk("set_preset", preset, 8'hF0);
                chk("set_clear", clear, 8'hFF);
                drain();
                chk("set_pulse_len", p_low - p0, 32'd2);
                chk("set_no_clear", c_low - c0, 32'd0);
                chk("set_preset_val", p_seen, 8'hF0);

                // CLR mask 0xFF
                p0 = p_low; c0 = c_low;
                send(CLR, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 8'd0);
                chk("clr_clear", clear, 8'h00);
                chk("clr_preset", preset, 8'hFF);
                drain();
                chk("clr_pulse_len", c_low - c0, 32'd2);
                chk("clr_no_preset", p_low - p0, 32'd0);

                // HOLD back to back with cmd_valid held high
                send(LOAD, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 8'd0);
                drain();
                chk_d_val = 8'h3C;
                chk_d_en  = 1'b1;
                prev = 0;
                for (int i = 0; i < 4; i++) begin
                    send(HOLD, 8'hC3, 1'b1, 1'b1, 8'h3C, 1'b1, 8'd0);
                    if (i > 0) chk("hold_period", last_acc - prev, 32'd4);
                    prev = last_acc;
                end
                cmd_valid = 1'b0;
                drain();
                chk_d_en = 1'b0;

                // SET with empty mask: timing only, no force pulses
                p0 = p_low; c0 = c_low;
                send(SET, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1, 8'd0);
                drain();
                chk("mask0_pulses", (p_low - p0) + (c_low - c0), 32'd0);

                // Reset during DRIVE of a SET aborts it
                send(SET, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
                chk("abort_preset_before", preset, 8'h3C);
                rst = 1'b1;
                @(negedge clk);
                chk("abort_preset", preset, 8'hFF);
                chk("abort_clear", clear, 8'hFF);
                chk("abort_ready", cmd_ready, 1'b0);
                chk("abort_busy", busy, 1'b0);
                rst = 1'b0;
                @(negedge clk);
                chk("abort_ready_back", cmd_ready, 1'b1);
                repeat (6) @(negedge clk);
                send(HOLD, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 8'd0);
                drain();

                // Stuck-at-1 on bit 3, repeated until the counter saturates
                stuck = 8'h08;
                for (int k = 1; k <= 300; k++) begin
                    send(LOAD, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0, (k > 255) ? 8'd255 : 8'(k));
                end
                drain();
                chk("err_saturated", err_count, 8'd255);
                stuck = 8'h00;
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flop_bank_ctrl.md
Name: flop_bank_ctrl

Overview:
- Command sequencer that sits directly upstream of a bank of WIDTH preset/clear D flip-flops and drives their preset, clear and d inputs.
- Preset and clear on the flops are active-low: preset=0 forces q=1, clear=0 forces q=0, both high means q<=d at clk, and both low is illegal (q=x).
- Takes SET/CLR/LOAD/HOLD commands over a valid/ready handshake and holds the force pulses for a programmable length.
- Never drives the illegal preset=0 & clear=0 pair. Keeps a shadow of the expected q, compares it with the bank's returned q, and counts mismatches.

Parameters:
- WIDTH, 8, number of flops in the bank.
- PULSE_CYC, 2, cycles preset/clear are held low for SET/CLR (legal range 1..15).
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  opcode: 00 HOLD, 01 SET, 10 CLR, 11 LOAD.
- cmd_data  input  WIDTH  bit mask for SET/CLR; load value for LOAD; ignored for HOLD.
- preset  output  WIDTH  active-low preset to the flop bank.
- clear  output  WIDTH  active-low clear to the flop bank.
- d  output  WIDTH  data to the flop bank.
- q_in  input  WIDTH  q returned from the flop bank.
- rsp_valid  output  1  one-cycle pulse when a command completes.
- rsp_match  output  1  q_in==shadow at check time; valid with rsp_valid.
- rsp_q  output  WIDTH  sampled q_in; valid with rsp_valid.
- err_count  output  CNT_W  saturating mismatch count.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - preset=all 1, clear=all 1, d=0, shadow=0;
  - rsp_valid=0, rsp_match=0, rsp_q=0, err_count=0;
  - state=IDLE, cmd_ready=0 (cmd_ready rises the cycle after rst deasserts).
- Reset mid-command aborts it: there is no rsp_valid, shadow is cleared, and preset/clear go high at that same edge.
- States: IDLE, DRIVE, LOAD, SETTLE, CHECK.
- IDLE:
  - cmd_ready=1, preset=clear=all 1, d=shadow.
  - On the edge where cmd_valid & cmd_ready, latch op/data and drop cmd_ready.
  - SET/CLR -> DRIVE with cnt=PULSE_CYC-1; LOAD/HOLD -> LOAD.
- DRIVE:
  - SET: preset[i]=~mask[i], clear=all 1.
  - CLR: clear[i]=~mask[i], preset=all 1.
  - d=shadow, so unmasked bits reload their own value.
  - Lasts exactly PULSE_CYC cycles (cnt decrements to 0), then -> SETTLE.
  - Shadow update at exit: SET: shadow|=mask; CLR: shadow&=~mask.
- LOAD:
  - One cycle with preset=clear=all 1.
  - d=data for LOAD, d=shadow for HOLD.
  - Shadow=data for LOAD (HOLD leaves it unchanged). Then -> SETTLE.
- SETTLE:
  - One cycle with preset=clear=all 1 and d=shadow (the updated shadow). Gives the flop one capture edge.
  - Then -> CHECK.
- CHECK:
  - Sample q_in and drive rsp_valid=1 for one cycle, with rsp_q=q_in and rsp_match=(q_in==shadow).
  - If there is a mismatch, err_count+=1, saturating at 2^CNT_W-1.
  - Then -> IDLE.
- Latency from the accept edge to the rsp_valid cycle: SET/CLR = PULSE_CYC+2 cycles; LOAD/HOLD = 3 cycles.
- Invariant: for every bit i and every cycle, preset[i] | clear[i] == 1. Both low must never occur, including during and after reset.
- A mask of 0 with SET/CLR is legal: there are no force pulses, only the timing.
- cmd_valid while cmd_ready=0 is ignored. Commands are not queued; the source must hold cmd_valid until accepted.
- Back-to-back: cmd_ready returns in the cycle after CHECK, so the minimum command period is latency+1 cycles.
- Outputs are registered; there are no combinational paths from cmd_* or q_in to any output.

Test Plan:
- Reset with WIDTH=8, then LOAD 0xA5 on a model flop bank -> d=0xA5 in the LOAD cycle; rsp_valid 3 cycles after accept; rsp_q=0xA5, rsp_match=1, err_count=0.
- SET mask 0x0F with PULSE_CYC=2 from shadow 0xA5 -> preset=0xF0 and clear=0xFF for exactly 2 cycles; rsp_q=0xAF, rsp_match=1; latency 4.
- CLR mask 0xFF -> clear=0x00 for 2 cycles, preset stays 0xFF; rsp_q=0x00; a bench assertion checks preset|clear==0xFF every cycle across the whole test.
- Bank model with bit 3 stuck at 1, then LOAD 0x00 -> rsp_match=0, rsp_q=0x08, err_count=1. Repeat 300 times with CNT_W=8 -> err_count saturates at 255.
- Assert rst for one cycle during DRIVE of a SET -> preset/clear all 1 on that edge, no rsp_valid, shadow=0; cmd_ready=1 one cycle after rst falls.
- Hold cmd_valid high with HOLD commands back to back -> one accept every 4 cycles; rsp_q equals the prior shadow and d=shadow throughout.
